// File: rtl/div.sv
// Signed restoring divider with truncating semantics.
// An operation is accepted from IDLE or DONE and runs NUM_BITS shift-subtract
// steps on operand magnitudes. A sign fix-up step follows the iterations, and
// the result is then held in DONE.
// A zero divisor is caught on the first CALC cycle and bypasses the
// iterations. Dividing the most negative value by -1 wraps and raises desborde.
module div #(
    parameter int NUM_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inicio,
    input  logic [NUM_BITS-1:0] dividendo,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] cociente,
    output logic [NUM_BITS-1:0] resto,
    output logic                Fin,
    output logic                div_cero,
    output logic                desborde
);

    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(NUM_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [NUM_BITS-1:0] dvd_q;      // raw dividend, returned as remainder on divide-by-zero
    logic [NUM_BITS:0]   quo_q;      // dividend magnitude shifting out, quotient bits shifting in
    logic [NUM_BITS:0]   rem_q;      // partial remainder magnitude
    logic [NUM_BITS:0]   dsr_q;      // divisor magnitude
    logic                q_neg_q;
    logic                r_neg_q;
    logic [NUM_BITS-1:0] cociente_q;
    logic [NUM_BITS-1:0] resto_q;
    logic                fin_q;
    logic                div_cero_q;
    logic                desborde_q;

    // Operand magnitudes are one bit wider so that |MIN| is representable.
    logic [NUM_BITS:0]   dvd_ext_s;
    logic [NUM_BITS:0]   dsr_ext_s;
    logic [NUM_BITS:0]   dvd_mag_s;
    logic [NUM_BITS:0]   dsr_mag_s;
    logic [NUM_BITS+1:0] trial_s;
    logic                ge_s;
    logic [NUM_BITS:0]   rem_d;
    logic [NUM_BITS:0]   quo_d;
    logic [NUM_BITS:0]   q_res_s;
    logic [NUM_BITS-1:0] r_res_s;

    // Magnitudes of the incoming operands, formed in NUM_BITS+1 bits.
    always_comb begin
        dvd_ext_s = {dividendo[NUM_BITS-1], dividendo};
        dsr_ext_s = {divisor[NUM_BITS-1], divisor};
        if (dividendo[NUM_BITS-1]) begin
            dvd_mag_s = {(NUM_BITS+1){1'b0}} - dvd_ext_s;
        end else begin
            dvd_mag_s = dvd_ext_s;
        end
        if (divisor[NUM_BITS-1]) begin
            dsr_mag_s = {(NUM_BITS+1){1'b0}} - dsr_ext_s;
        end else begin
            dsr_mag_s = dsr_ext_s;
        end
    end

    // One restoring step: shift the next dividend bit in and subtract when it fits.
    always_comb begin
        trial_s = {rem_q, quo_q[NUM_BITS-1]};
        ge_s    = (trial_s >= {1'b0, dsr_q});
        if (ge_s) begin
            rem_d = trial_s[NUM_BITS:0] - dsr_q;
        end else begin
            rem_d = trial_s[NUM_BITS:0];
        end
        quo_d = {1'b0, quo_q[NUM_BITS-2:0], ge_s};
    end

    // Sign fix-up; the quotient is kept one bit wider so wrap on MIN/-1 is visible.
    always_comb begin
        if (q_neg_q) begin
            q_res_s = {(NUM_BITS+1){1'b0}} - quo_q;
        end else begin
            q_res_s = quo_q;
        end
        if (r_neg_q) begin
            r_res_s = {NUM_BITS{1'b0}} - rem_q[NUM_BITS-1:0];
        end else begin
            r_res_s = rem_q[NUM_BITS-1:0];
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            dvd_q      <= {NUM_BITS{1'b0}};
            quo_q      <= {(NUM_BITS+1){1'b0}};
            rem_q      <= {(NUM_BITS+1){1'b0}};
            dsr_q      <= {(NUM_BITS+1){1'b0}};
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            cociente_q <= {NUM_BITS{1'b0}};
            resto_q    <= {NUM_BITS{1'b0}};
            fin_q      <= 1'b0;
            div_cero_q <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (inicio) begin
                        dvd_q      <= dividendo;
                        quo_q      <= dvd_mag_s;
                        rem_q      <= {(NUM_BITS+1){1'b0}};
                        dsr_q      <= dsr_mag_s;
                        q_neg_q    <= dividendo[NUM_BITS-1] ^ divisor[NUM_BITS-1];
                        r_neg_q    <= dividendo[NUM_BITS-1];
                        cnt_q      <= {CW{1'b0}};
                        fin_q      <= 1'b0;
                        div_cero_q <= 1'b0;
                        desborde_q <= 1'b0;
                        state_q    <= CALC;
                    end else begin
                        state_q    <= state_q;
                    end
                end
                CALC: begin
                    if (dsr_q == {(NUM_BITS+1){1'b0}}) begin
                        cociente_q <= {NUM_BITS{1'b1}};
                        resto_q    <= dvd_q;
                        div_cero_q <= 1'b1;
                        fin_q      <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        if (cnt_q == LAST_ITER) begin
                            cnt_q   <= {CW{1'b0}};
                            state_q <= FIX;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                end
                FIX: begin
                    cociente_q <= q_res_s[NUM_BITS-1:0];
                    resto_q    <= r_res_s;
                    desborde_q <= q_res_s[NUM_BITS] ^ q_res_s[NUM_BITS-1];
                    fin_q      <= 1'b1;
                    state_q    <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cociente = cociente_q;
    assign resto    = resto_q;
    assign Fin      = fin_q;
    assign div_cero = div_cero_q;
    assign desborde = desborde_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (NUM_BITS=3): directed vector table, exhaustive
// and random operands against an arithmetic reference, plus hand-written
// sequences for held start, reset mid-operation and operand changes mid-CALC.
module tb_div;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic         inicio;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic [N-1:0] cociente;
    logic [N-1:0] resto;
    logic         Fin;
    logic         div_cero;
    logic         desborde;

    int n_checks = 0;
    int n_errors = 0;

    // Outputs the bench expects the DUT to be holding between results.
    logic [N-1:0] last_q;
    logic [N-1:0] last_r;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    div #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .resto     (resto),
        .Fin       (Fin),
        .div_cero  (div_cero),
        .desborde  (desborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic plus the two special cases.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dz, output logic ov, output int lat);
        int sa, sb, mn, qi, ri;
        sa = $signed(a);
        sb = $signed(b);
        mn = -(1 << (N - 1));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else if (sa == mn && sb == -1) begin
            q = a; r = '0; ov = 1'b1; lat = N + 1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            q = N'(qi);
            r = N'(ri);
            lat = N + 1;
        end
    endtask

    // Start one operation, scramble the inputs after the latch edge, wait for Fin.
    task automatic run_vec(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic edz, input logic eov, input int elat);
        int lat;
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        inicio    = 1'b1;
        @(posedge clk);
        #1;
        inicio    = 1'b0;
        dividendo = N'($urandom);
        divisor   = N'($urandom);
        chk({name, "/fin_clr"}, Fin, 1'b0);
        lat = 0;
        while (Fin !== 1'b1 && lat < 20) begin
            chk({name, "/hold_q"}, cociente, last_q);
            chk({name, "/hold_r"}, resto, last_r);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "/latency"}, lat, elat);
        chk({name, "/q"}, cociente, eq);
        chk({name, "/r"}, resto, er);
        chk({name, "/dz"}, div_cero, edz);
        chk({name, "/ov"}, desborde, eov);
        last_q = eq;
        last_r = er;
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] q, r;
        logic dz, ov;
        int lat;
        model(a, b, q, r, dz, ov, lat);
        run_vec(name, a, b, q, r, dz, ov, lat);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        inicio    = 1'b0;
        dividendo = '0;
        divisor   = '0;
        last_q    = '0;
        last_r    = '0;

        tbl[0] = '{3'b011, 3'b110, 3'b111, 3'b001, 1'b0, 1'b0, 4};
        tbl[1] = '{3'b100, 3'b111, 3'b100, 3'b000, 1'b0, 1'b1, 4};
        tbl[2] = '{3'b011, 3'b000, 3'b111, 3'b011, 1'b1, 1'b0, 1};
        tbl[3] = '{3'b010, 3'b001, 3'b010, 3'b000, 1'b0, 1'b0, 4};
        tbl[4] = '{3'b100, 3'b011, 3'b111, 3'b111, 1'b0, 1'b0, 4};
        tbl[5] = '{3'b101, 3'b010, 3'b111, 3'b111, 1'b0, 1'b0, 4};
        tbl[6] = '{3'b100, 3'b001, 3'b100, 3'b000, 1'b0, 1'b0, 4};
        tbl[7] = '{3'b000, 3'b000, 3'b111, 3'b000, 1'b1, 1'b0, 1};
        tbl[8] = '{3'b011, 3'b011, 3'b001, 3'b000, 1'b0, 1'b0, 4};
        tbl[9] = '{3'b111, 3'b101, 3'b000, 3'b111, 1'b0, 1'b0, 4};

        // Asynchronous reset: outputs clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst/q", cociente, 3'b000);
        chk("rst/r", resto, 3'b000);
        chk("rst/fin", Fin, 1'b0);
        chk("rst/flags", {div_cero, desborde}, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                    tbl[i].dz, tbl[i].ov, tbl[i].lat);
        end

        // DONE holds the result while inicio stays low.
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold/fin", Fin, 1'b1);
        chk("done_hold/q", cociente, last_q);
        chk("done_hold/r", resto, last_r);

        // Every operand pair, each started straight out of DONE.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_op($sformatf("all_%0d_%0d", a, b), N'(a), N'(b));
            end
        end

        // Random operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", i), N'($urandom), N'($urandom));
        end

        // inicio held high: back-to-back operations, Fin every N+2 edges.
        @(negedge clk);
        dividendo = 3'b011;
        divisor   = 3'b110;
        inicio    = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held/fin%0d", j), Fin, ((j % 5) == 4) ? 1'b1 : 1'b0);
            if ((j % 5) == 4) begin
                chk($sformatf("held/q%0d", j), cociente, 3'b111);
                chk($sformatf("held/r%0d", j), resto, 3'b001);
            end
        end
        inicio = 1'b0;
        lat = 0;
        while (Fin !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held/final_lat", lat, 4);
        chk("held/final_q", cociente, 3'b111);
        last_q = 3'b111;
        last_r = 3'b001;

        // Reset in the middle of CALC abandons the operation.
        @(negedge clk);
        dividendo = 3'b101;
        divisor   = 3'b010;
        inicio    = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst/q", cociente, 3'b000);
        chk("midrst/r", resto, 3'b000);
        chk("midrst/fin", Fin, 1'b0);
        chk("midrst/flags", {div_cero, desborde}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d/fin", j), Fin, 1'b0);
            chk($sformatf("idle%0d/qr", j), {cociente, resto}, 6'b000000);
        end
        last_q = '0;
        last_r = '0;
        run_vec("after_rst", 3'b010, 3'b001, 3'b010, 3'b000, 1'b0, 1'b0, 4);

        // Operand changes and an inicio pulse during CALC do not disturb the result.
        @(negedge clk);
        dividendo = 3'b100;
        divisor   = 3'b011;
        inicio    = 1'b1;
        @(posedge clk);
        #1;
        inicio    = 1'b0;
        dividendo = 3'b011;
        divisor   = 3'b001;
        lat = 0;
        while (Fin !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            inicio = (lat == 1) ? 1'b1 : 1'b0;
        end
        inicio = 1'b0;
        chk("calc_change/lat", lat, 4);
        chk("calc_change/q", cociente, 3'b111);
        chk("calc_change/r", resto, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        chk("calc_change/fin_hold", Fin, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
